// File: rtl/modulo_entrada_pkg.sv
// rtl/modulo_entrada_pkg.sv - shared debounce state codes and data widths for modulo_entrada
package modulo_entrada_pkg;

    localparam int DADOS_W = 8;
    localparam int ZEXT_W  = 24;

    typedef logic [1:0] estado_t;

    localparam estado_t SOLTO       = 2'd0;
    localparam estado_t CONF_PRESS  = 2'd1;
    localparam estado_t PRESSIONADO = 2'd2;
    localparam estado_t CONF_SOLTA  = 2'd3;

endpackage

// File: rtl/modulo_entrada_debounce.sv
// rtl/modulo_entrada_debounce.sv - debounce_tecla: key synchronizer, stability counter and press FSM
module debounce_tecla
    import modulo_entrada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tecla,
    output logic       captura,
    output logic [1:0] estado
);

    localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS - 1);

    logic       tecla_m;
    logic       tecla_s;
    logic [7:0] cnt;
    estado_t    est;

    // Starting in CONF_SOLTA means a key held through reset must be released first.
    always_ff @(posedge clk) begin
        if (reset) begin
            tecla_m <= 1'b0;
            tecla_s <= 1'b0;
            cnt     <= 8'd0;
            est     <= CONF_SOLTA;
        end else begin
            tecla_m <= tecla;
            tecla_s <= tecla_m;
            case (est)
                SOLTO: begin
                    if (tecla_s) begin
                        est <= CONF_PRESS;
                        cnt <= 8'd0;
                    end
                end
                CONF_PRESS: begin
                    if (!tecla_s)
                        est <= SOLTO;
                    else if (cnt == LIMITE)
                        est <= PRESSIONADO;
                    else
                        cnt <= cnt + 8'd1;
                end
                PRESSIONADO: begin
                    if (!tecla_s) begin
                        est <= CONF_SOLTA;
                        cnt <= 8'd0;
                    end
                end
                default: begin
                    if (tecla_s)
                        est <= PRESSIONADO;
                    else if (cnt == LIMITE)
                        est <= SOLTO;
                    else
                        cnt <= cnt + 8'd1;
                end
            endcase
        end
    end

    assign captura = (est == CONF_PRESS) && tecla_s && (cnt == LIMITE);
    assign estado  = est;

endmodule

// File: rtl/modulo_entrada.sv
// rtl/modulo_entrada.sv - enter/switch input front-end; MODULO_ENTRADA_FIFO_EN selects FIFO over single register
module modulo_entrada
    import modulo_entrada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int FIFO_PROF       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dadosIN,
    input  logic        enter,
    input  logic        lido,
    output logic [31:0] dado,
    output logic        valido,
    output logic        perda,
    output logic [2:0]  nivel
);

    localparam int NW = $clog2(FIFO_PROF + 1);

    logic [DADOS_W-1:0] dados_m;
    logic [DADOS_W-1:0] dados_s;
    logic               captura;
    logic [1:0]         estado;
    logic               push;
    logic               pop;
    logic               aceita;
    logic [DADOS_W-1:0] cabeca_q;
    logic               valido_q;
    logic               perda_q;
    logic [NW-1:0]      nivel_q;

    debounce_tecla #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .tecla   (enter),
        .captura (captura),
        .estado  (estado)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dados_m <= '0;
            dados_s <= '0;
        end else begin
            dados_m <= dadosIN;
            dados_s <= dados_m;
        end
    end

    // A capture strobe is only meaningful while confirming a press.
    assign push = captura && (estado == CONF_PRESS);
    assign pop  = lido && valido_q;

`ifdef MODULO_ENTRADA_FIFO_EN
    localparam int            PW    = $clog2(FIFO_PROF);
    localparam logic [NW-1:0] CHEIO = NW'(FIFO_PROF);

    logic [DADOS_W-1:0] mem [FIFO_PROF];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      rd_next;
    logic [NW-1:0]      nivel_next;
    logic [DADOS_W-1:0] cabeca_next;

    // The head register is loaded with the post-edge head, forwarding a word
    // that is written into the slot becoming the head on the same edge.
    always_comb begin
        aceita      = push && ((nivel_q != CHEIO) || pop);
        rd_next     = rd_ptr + PW'(pop);
        nivel_next  = nivel_q + NW'(aceita) - NW'(pop);
        cabeca_next = '0;
        if (nivel_next != '0) begin
            if (aceita && (wr_ptr == rd_next))
                cabeca_next = dados_s;
            else
                cabeca_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && aceita)
            mem[wr_ptr] <= dados_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            nivel_q  <= '0;
            valido_q <= 1'b0;
            cabeca_q <= '0;
        end else begin
            if (aceita)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr   <= rd_next;
            nivel_q  <= nivel_next;
            valido_q <= (nivel_next != '0);
            cabeca_q <= cabeca_next;
        end
    end
`else
    always_comb begin
        aceita = push && (!valido_q || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cabeca_q <= '0;
            valido_q <= 1'b0;
            nivel_q  <= '0;
        end else if (aceita) begin
            cabeca_q <= dados_s;
            valido_q <= 1'b1;
            nivel_q  <= NW'(1);
        end else if (pop) begin
            cabeca_q <= '0;
            valido_q <= 1'b0;
            nivel_q  <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            perda_q <= 1'b0;
        else if (push && !aceita)
            perda_q <= 1'b1;
    end

    assign dado   = {{ZEXT_W{1'b0}}, cabeca_q};
    assign valido = valido_q;
    assign perda  = perda_q;
    assign nivel  = 3'(nivel_q);

endmodule
